// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
// Shared definitions for the interrupt controller and the fetch/decode stages
// that talk to it.
//   - int_state_e    : controller FSM state encoding
//   - RTI_OPCODE     : return-from-interrupt opcode, decoded by fetch to
//                      produce int_done
//   - HANDLER_VECTOR : address fetch jumps to when it accepts ipu_int
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_e;

    localparam logic [3:0]  RTI_OPCODE     = 4'b0011;
    localparam logic [15:0] HANDLER_VECTOR = 16'h0005;

endpackage

// File: rtl/int_sync_edge.sv
// -----------------------------------------------------------------------------
// int_sync_edge
// Brings one asynchronous board signal into the clk domain and produces a
// single-cycle pulse on each of its rising edges.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   src_i  : raw asynchronous source
//   edge_o : one-cycle pulse, high when the synchronised level has just risen
// -----------------------------------------------------------------------------
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;

    // Synchroniser chain followed by one extra delay flop; comparing the last
    // synchroniser stage against the delay flop gives the rising edge, so a
    // level held high yields exactly one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], src_i};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~delay_q;

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// Interrupt controller sitting directly upstream of fetch. Latches rising
// edges of NUM_SRC asynchronous sources as pending, picks the lowest-index
// unmasked pending source, requests fetch on ipu_int and waits for the
// handler's RTI (int_done) before issuing the next request.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   src_in     : raw asynchronous sources, rising-edge triggered
//   int_ack    : fetch accepted ipu_int (one-cycle pulse)
//   int_done   : RTI is in fetch
//   mask_we    : mask register write strobe from the memory stage
//   mask_wdata : new mask value, 1 = source enabled
//   ipu_int    : interrupt request to fetch
//   int_cause  : index of the source being serviced
//   int_active : high from request until RTI
//   pending    : pending-bit vector (debug / LEDs)
// -----------------------------------------------------------------------------
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               int_ack,
    input  logic               int_done,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic               ipu_int,
    output logic [CW-1:0]      int_cause,
    output logic               int_active,
    output logic [NUM_SRC-1:0] pending
);

    int_state_e         state_q;
    logic               ipu_q;
    logic               active_q;
    logic [CW-1:0]      cause_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] edge_w;
    logic [NUM_SRC-1:0] ready_w;
    logic [NUM_SRC-1:0] clr_w;
    logic [CW-1:0]      sel_w;
    logic               any_w;

    // One synchroniser/edge detector per source.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        int_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk   (clk),
            .rst   (rst),
            .src_i (src_in[i]),
            .edge_o(edge_w[i])
        );
    end

    assign ready_w = pending_q & mask_q;
    assign any_w   = |ready_w;

    // Priority encoder: scanning from the top down lets the lowest index
    // overwrite, so index 0 wins.
    always_comb begin
        sel_w = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (ready_w[i]) begin
                sel_w = CW'(i);
            end
        end
    end

    // The selected bit is cleared only on the IDLE->REQ step. New edges are
    // OR-ed in after the clear so a coincident edge keeps the bit set.
    always_comb begin
        clr_w = '0;
        if (state_q == IDLE && any_w) begin
            clr_w[sel_w] = 1'b1;
        end
        pending_d = (pending_q & ~clr_w) | edge_w;
    end

    // Pending and mask registers. Edges latch regardless of the mask, so a
    // masked source fires later once it is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '1;
        end else begin
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    // Request/service FSM with registered outputs. REQ waits only for
    // int_ack and SERVICE waits only for int_done; stray pulses of the other
    // handshake signal are ignored in each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ipu_q    <= 1'b0;
            active_q <= 1'b0;
            cause_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_w) begin
                        state_q  <= REQ;
                        ipu_q    <= 1'b1;
                        active_q <= 1'b1;
                        cause_q  <= sel_w;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state_q <= SERVICE;
                        ipu_q   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (int_done) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ipu_q    <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign ipu_int    = ipu_q;
    assign int_active = active_q;
    assign int_cause  = cause_q;
    assign pending    = pending_q;

endmodule
